// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
//
// Memory-mapped machine timer that answers on the core/memory system bus as a
// responder. The top-level address decoder drives i_sel. The block holds a
// 64-bit mtime counter with a programmable prescaler, a 64-bit mtimecmp
// compare register and a registered level interrupt to the core.
//
// Every access takes exactly one wait state. A request is accepted in cycle N,
// and the block answers with o_ready in cycle N+1. The fastest possible rate
// is therefore one access every two cycles.
//
// Register map (32-bit words, addressed by i_addr[4:2]):
//   0x00 MTIME_LO     live mtime[31:0]; reading it also latches mtime[63:32]
//                     into the hi shadow
//   0x04 MTIME_HI     reads return the hi shadow; writes go to mtime[63:32]
//   0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL         bit0 EN, bit1 IRQ_EN
//   0x14 PRESCALE     [PRESCALE_W-1:0]
//   Offsets not listed here read as 0, and writes to them are ignored.
//
// Parameters:
//   PRESCALE_W        width of PRESCALE and of the prescale counter (1..32)
//   DEFAULT_PRESCALE  reset value of PRESCALE
//
// Ports:
//   i_clk     system clock
//   i_rst     synchronous, active-high reset
//   i_sel     address decoder hit for this block
//   i_addr    byte offset; bits [1:0] are ignored
//   i_re      read request
//   i_we      write request; wins over i_re
//   i_be      byte enables for writes; i_be[i] covers i_wdata[8i+7:8i]
//   i_wdata   write data
//   o_rdata   read data; valid only while o_ready is high
//   o_ready   one-cycle access completion strobe
//   o_irq     timer interrupt (level, registered)
// -----------------------------------------------------------------------------
module bus_timer #(
  parameter int                     PRESCALE_W       = 16,
  parameter logic [PRESCALE_W-1:0]  DEFAULT_PRESCALE = '0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic [4:0]  i_addr,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_irq
);

  // Word offsets, decoded from i_addr[4:2]
  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_PRESCALE    = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic [1:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_prescCnt;
  logic [31:0]           r_hiShadow;
  logic [31:0]           r_rdata;
  logic                  r_irq;

  logic [2:0]            w_offset;
  logic                  w_accept;
  logic                  w_wrEn;
  logic                  w_rdEn;
  logic                  w_tick;
  logic [31:0]           w_prescaleExt;
  logic [31:0]           w_readData;
  logic [63:0]           w_mtimeNext;
  logic [PRESCALE_W-1:0] w_prescCntNext;
  logic                  w_unusedAddr;

  // Replace only the bytes whose enable is set; the other bytes keep
  // their old value.
  function automatic logic [31:0] mergeBytes(
    input logic [31:0] oldVal,
    input logic [31:0] newVal,
    input logic [3:0]  byteEn
  );
    logic [31:0] res;
    res = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        res[8*i +: 8] = newVal[8*i +: 8];
      end
    end
    return res;
  endfunction

  // The two low address bits select a byte within a word and have no
  // meaning for word-wide registers.
  assign w_unusedAddr = &{1'b0, i_addr[1:0]};

  assign w_offset      = i_addr[4:2];
  assign w_accept      = (r_state == ST_IDLE) && i_sel && (i_re || i_we);
  assign w_wrEn        = w_accept && i_we;
  assign w_rdEn        = w_accept && !i_we;
  assign w_tick        = r_ctrl[0] && (r_prescCnt == r_prescale);
  assign w_prescaleExt = 32'(r_prescale);

  // Handshake FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Handshake FSM: next state. RESP always lasts exactly one cycle, and any
  // request that arrives while in RESP is ignored.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_stateNext = ST_RESP;
      ST_RESP: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Read multiplexer. MTIME_HI returns the shadow that was latched by the
  // last MTIME_LO read, so that a LO-then-HI read pair is coherent.
  always_comb begin
    w_readData = 32'd0;
    case (w_offset)
      OFF_MTIME_LO:    w_readData = r_mtime[31:0];
      OFF_MTIME_HI:    w_readData = r_hiShadow;
      OFF_MTIMECMP_LO: w_readData = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_readData = r_mtimecmp[63:32];
      OFF_CTRL:        w_readData = {30'd0, r_ctrl};
      OFF_PRESCALE:    w_readData = w_prescaleExt;
      default:         w_readData = 32'd0;
    endcase
  end

  // Next mtime. A tick adds 1 with a full 64-bit carry. A bus write to
  // either half replaces that tick entirely: the written half takes the
  // new bytes, and the other half keeps its pre-tick value.
  always_comb begin
    w_mtimeNext = r_mtime;
    if (w_tick) begin
      w_mtimeNext = r_mtime + 64'd1;
    end
    if (w_wrEn && (w_offset == OFF_MTIME_LO)) begin
      w_mtimeNext = {r_mtime[63:32], mergeBytes(r_mtime[31:0], i_wdata, i_be)};
    end else if (w_wrEn && (w_offset == OFF_MTIME_HI)) begin
      w_mtimeNext = {mergeBytes(r_mtime[63:32], i_wdata, i_be), r_mtime[31:0]};
    end
  end

  // Next prescale counter. It only moves while EN is set, and it restarts
  // from 0 whenever PRESCALE is written so the new period starts cleanly.
  always_comb begin
    w_prescCntNext = r_prescCnt;
    if (r_ctrl[0]) begin
      w_prescCntNext = w_tick ? '0 : r_prescCnt + 1'b1;
    end
    if (w_wrEn && (w_offset == OFF_PRESCALE)) begin
      w_prescCntNext = '0;
    end
  end

  // Timer state and programmable registers. Reset takes priority over a
  // write that is accepted in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_ctrl     <= 2'd0;
      r_prescale <= DEFAULT_PRESCALE;
      r_prescCnt <= '0;
    end else begin
      r_mtime    <= w_mtimeNext;
      r_prescCnt <= w_prescCntNext;
      if (w_wrEn) begin
        case (w_offset)
          OFF_MTIMECMP_LO:
            r_mtimecmp[31:0]  <= mergeBytes(r_mtimecmp[31:0], i_wdata, i_be);
          OFF_MTIMECMP_HI:
            r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], i_wdata, i_be);
          OFF_CTRL:
            if (i_be[0]) r_ctrl <= i_wdata[1:0];
          OFF_PRESCALE:
            r_prescale <= PRESCALE_W'(mergeBytes(w_prescaleExt, i_wdata, i_be));
          default: ;
        endcase
      end
    end
  end

  // Bus response. Read data is captured on the accept edge, and a write
  // answers with 0. Outside RESP the data bus is held at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata    <= 32'd0;
      r_hiShadow <= 32'd0;
    end else begin
      r_rdata <= w_rdEn ? w_readData : 32'd0;
      if (w_rdEn && (w_offset == OFF_MTIME_LO)) begin
        r_hiShadow <= r_mtime[63:32];
      end
    end
  end

  // Interrupt. The compare uses this cycle's register values, so the level
  // shows up one cycle after the condition becomes true.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl[1] && (r_mtime >= r_mtimecmp);
    end
  end

  assign o_ready = (r_state == ST_RESP);
  assign o_rdata = r_rdata;
  assign o_irq   = r_irq;

endmodule

// File: tb/tb_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_bus_timer
//
// Scoreboard bench for bus_timer. The reference model advances mtime from
// the timer rules using plain integer arithmetic. Each accepted access
// pushes its expected response onto a queue. A separate monitor pops that
// queue whenever o_ready is high, and it also compares o_irq on every cycle.
// -----------------------------------------------------------------------------
module tb_bus_timer;

  localparam int             PW           = 16;
  localparam logic [PW-1:0]  DEF_PRESCALE = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [4:0]  addr;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  always #5 clk = ~clk;

  bus_timer #(
    .PRESCALE_W      (PW),
    .DEFAULT_PRESCALE(DEF_PRESCALE)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sel  (sel),
    .i_addr (addr),
    .i_re   (re),
    .i_we   (we),
    .i_be   (be),
    .i_wdata(wdata),
    .o_rdata(rdata),
    .o_ready(ready),
    .o_irq  (irq)
  );

  int          checks  = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  bit          started = 1'b0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t expQ[$];

  // Reference model state
  logic [63:0] mMtime  = 64'd0;
  logic [63:0] mCmp    = '1;
  bit          mEn     = 1'b0;
  bit          mIrqEn  = 1'b0;
  logic [31:0] mPresc  = 32'(DEF_PRESCALE);
  logic [31:0] mCnt    = 32'd0;
  logic [31:0] mShadow = 32'd0;
  bit          mIrq    = 1'b0;
  bit          mBusy   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] modelMerge(input logic [31:0] oldV, input logic [31:0] newV, input logic [3:0] byteEn);
    logic [31:0] r;
    r = oldV;
    for (int i = 0; i < 4; i++) if (byteEn[i]) r[8*i +: 8] = newV[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input int off);
    case (off)
      0:       return mMtime[31:0];
      1:       return mShadow;
      2:       return mCmp[31:0];
      3:       return mCmp[63:32];
      4:       return {30'd0, mIrqEn, mEn};
      5:       return mPresc;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: mtime goes up by one every (PRESCALE+1) enabled cycles.
  // An accepted access is answered in the following cycle.
  always @(posedge clk) begin
    logic [63:0] nMtime;
    logic [31:0] nCnt;
    logic [31:0] rd;
    bit          tick;
    bit          acc;
    bit          nIrq;
    int          off;
    cyc++;
    if (rst) begin
      mMtime = 64'd0; mCmp = '1; mEn = 1'b0; mIrqEn = 1'b0;
      mPresc = 32'(DEF_PRESCALE); mCnt = 32'd0; mShadow = 32'd0;
      mIrq = 1'b0; mBusy = 1'b0;
      expQ.delete();
    end else begin
      nIrq   = mIrqEn && (mMtime >= mCmp);
      tick   = mEn && (mCnt == mPresc);
      nMtime = mMtime + (tick ? 64'd1 : 64'd0);
      nCnt   = !mEn ? mCnt : (tick ? 32'd0 : mCnt + 32'd1);
      acc    = !mBusy && sel && (re || we);
      off    = int'(addr[4:2]);
      if (acc && we) begin
        case (off)
          0: nMtime = {mMtime[63:32], modelMerge(mMtime[31:0], wdata, be)};
          1: nMtime = {modelMerge(mMtime[63:32], wdata, be), mMtime[31:0]};
          2: mCmp[31:0]  = modelMerge(mCmp[31:0], wdata, be);
          3: mCmp[63:32] = modelMerge(mCmp[63:32], wdata, be);
          4: if (be[0]) begin mEn = wdata[0]; mIrqEn = wdata[1]; end
          5: begin mPresc = modelMerge(mPresc, wdata, be) & 32'h0000_FFFF; nCnt = 32'd0; end
          default: ;
        endcase
        expQ.push_back('{data: 32'd0, due: cyc});
      end else if (acc) begin
        rd = modelRead(off);
        if (off == 0) mShadow = mMtime[63:32];
        expQ.push_back('{data: rd, due: cyc});
      end
      mBusy  = acc;
      mMtime = nMtime;
      mCnt   = nCnt;
      mIrq   = nIrq;
    end
  end

  // Monitor: on every falling edge, compare the bus response and the
  // interrupt level against the model.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: got ready=1 expected no response at cycle %0d", cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("ready_cycle", 64'(cyc), 64'(e.due));
          checkOutput("rdata", 64'(rdata), 64'(e.data));
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        e = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missing_ready: got ready=0 expected ready=1 at cycle %0d", cyc);
      end
      checkOutput("irq", 64'(irq), 64'(mIrq));
    end
  end

  task automatic applyStimulus(input bit isWrite, input logic [4:0] a, input logic [3:0] b,
                               input logic [31:0] d, output logic [31:0] rdOut);
    @(negedge clk);
    sel = 1'b1; we = isWrite; re = !isWrite; addr = a; be = b; wdata = d;
    @(negedge clk);
    rdOut = rdata;
    sel = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    applyStimulus(1'b1, a, 4'hF, d, dummy);
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    applyStimulus(1'b0, a, 4'h0, 32'd0, d);
  endtask

  task automatic readAllReset(input string tag);
    logic [31:0] v;
    readReg(5'h00, v); checkOutput({tag, "_mtime_lo"}, 64'(v), 64'd0);
    readReg(5'h04, v); checkOutput({tag, "_mtime_hi"}, 64'(v), 64'd0);
    readReg(5'h08, v); checkOutput({tag, "_cmp_lo"}, 64'(v), 64'hFFFF_FFFF);
    readReg(5'h0C, v); checkOutput({tag, "_cmp_hi"}, 64'(v), 64'hFFFF_FFFF);
    readReg(5'h10, v); checkOutput({tag, "_ctrl"}, 64'(v), 64'd0);
    readReg(5'h14, v); checkOutput({tag, "_prescale"}, 64'(v), 64'(DEF_PRESCALE));
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] v2;
    bit          isW;
    logic [4:0]  a;
    logic [3:0]  b;
    logic [31:0] d;

    rst = 1'b1; sel = 1'b0; re = 1'b0; we = 1'b0; addr = 5'd0; be = 4'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    $display("[TB] reset values");
    readAllReset("rst");
    readReg(5'h18, v); checkOutput("unmapped_read", 64'(v), 64'd0);

    $display("[TB] prescaler");
    writeReg(5'h14, 32'd3);
    writeReg(5'h10, 32'd1);
    readReg(5'h00, v);
    repeat (40) @(negedge clk);
    readReg(5'h00, v2);
    checkRange("presc3_advance", v2 - v, 32'd9, 32'd12);
    writeReg(5'h14, 32'd0);
    readReg(5'h00, v);
    readReg(5'h00, v2);
    checkOutput("presc0_advance", 64'(v2 - v), 64'd2);

    $display("[TB] carry and write-on-tick");
    writeReg(5'h10, 32'd0);
    writeReg(5'h00, 32'hFFFF_FFFF);
    writeReg(5'h04, 32'd0);
    writeReg(5'h10, 32'd1);
    readReg(5'h00, v);  checkOutput("carry_lo", 64'(v), 64'd0);
    readReg(5'h04, v);  checkOutput("carry_hi", 64'(v), 64'd1);
    writeReg(5'h04, 32'h1234_5678);
    readReg(5'h00, v);
    readReg(5'h04, v);  checkOutput("hi_write_on_tick", 64'(v), 64'h1234_5678);

    $display("[TB] atomic snapshot");
    writeReg(5'h10, 32'd0);
    writeReg(5'h00, 32'hFFFF_FFFD);
    writeReg(5'h04, 32'd0);
    writeReg(5'h10, 32'd1);
    readReg(5'h00, v);  checkOutput("snap_lo", 64'(v), 64'hFFFF_FFFE);
    repeat (2) @(negedge clk);
    readReg(5'h04, v);  checkOutput("snap_hi", 64'(v), 64'd0);
    readReg(5'h00, v);
    readReg(5'h04, v);  checkOutput("snap_hi_after_wrap", 64'(v), 64'd1);

    $display("[TB] interrupt");
    writeReg(5'h10, 32'd0);
    writeReg(5'h00, 32'd0);
    writeReg(5'h04, 32'd0);
    writeReg(5'h0C, 32'd0);
    writeReg(5'h08, 32'h20);
    writeReg(5'h10, 32'd3);
    repeat (40) @(negedge clk);
    checkOutput("irq_high", 64'(irq), 64'd1);
    writeReg(5'h08, 32'h100);
    @(negedge clk);
    checkOutput("irq_fall", 64'(irq), 64'd0);
    writeReg(5'h10, 32'd1);
    writeReg(5'h08, 32'h20);
    repeat (3) @(negedge clk);
    checkOutput("irq_masked", 64'(irq), 64'd0);

    $display("[TB] byte enables");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 5'h08, 4'b0010, 32'hAABB_CCDD, v);
    readReg(5'h08, v);  checkOutput("byte_write", 64'(v), 64'hFFFF_CCFF);
    applyStimulus(1'b1, 5'h10, 4'b0000, 32'h3, v);
    readReg(5'h10, v);  checkOutput("be0_noop", 64'(v), 64'd0);

    $display("[TB] reset during access");
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 5'h0C; be = 4'hF; wdata = 32'd0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_accept_no_ready", 64'(ready), 64'd0);
    sel = 1'b0; we = 1'b0; rst = 1'b0;
    readReg(5'h0C, v);  checkOutput("rst_accept_discard", 64'(v), 64'hFFFF_FFFF);
    writeReg(5'h00, 32'h55);
    writeReg(5'h10, 32'd3);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 5'h08; be = 4'hF; wdata = 32'd5;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    readAllReset("rst_resp");

    $display("[TB] random accesses");
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      isW = 1'($urandom_range(0, 1));
      a   = 5'($urandom_range(0, 31));
      b   = 4'($urandom);
      d   = $urandom;
      if (a[4:2] == 3'd5) d = d & 32'h7;
      if (a[4:2] == 3'd3 || a[4:2] == 3'd1) d = d & 32'h1;
      applyStimulus(isW, a, b, d, v);
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
